// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between the fetch and data ports.
// Single outstanding transaction; cancelled fetches drain silently.
module sram_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,

    input  logic              inst_sram_req,
    input  logic              inst_sram_wr,
    input  logic [1:0]        inst_sram_size,
    input  logic [3:0]        inst_sram_wstrb,
    input  logic [ADDR_W-1:0] inst_sram_addr,
    input  logic [DATA_W-1:0] inst_sram_wdata,
    output logic              inst_sram_addr_ok,
    output logic              inst_sram_data_ok,
    output logic [DATA_W-1:0] inst_sram_rdata,

    input  logic              data_sram_req,
    input  logic              data_sram_wr,
    input  logic [1:0]        data_sram_size,
    input  logic [3:0]        data_sram_wstrb,
    input  logic [ADDR_W-1:0] data_sram_addr,
    input  logic [DATA_W-1:0] data_sram_wdata,
    output logic              data_sram_addr_ok,
    output logic              data_sram_data_ok,
    output logic [DATA_W-1:0] data_sram_rdata,

    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_n;
    logic              owner;
    logic              owner_n;
    logic              last_grant;
    logic              last_grant_n;
    logic              cancel;
    logic              cancel_n;
    logic              grant_inst;
    logic              grant_data;
    logic              resp_done;

    logic              lat_wr;
    logic [1:0]        lat_size;
    logic [3:0]        lat_wstrb;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    // Gated by resetn so no grant pulse leaks out while held in reset
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (state == IDLE && resetn) begin
            if (inst_sram_req && data_sram_req) begin
                grant_inst = last_grant;
                grant_data = !last_grant;
            end else begin
                grant_inst = inst_sram_req;
                grant_data = data_sram_req;
            end
        end
    end

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_grant_n = last_grant;
        cancel_n     = cancel;
        unique case (state)
            IDLE: begin
                if (grant_inst || grant_data) begin
                    state_n      = ADDR;
                    owner_n      = grant_data;
                    last_grant_n = grant_data;
                    cancel_n     = 1'b0;
                end
            end
            ADDR: begin
                if (flush && !owner) cancel_n = 1'b1;
                if (mem_addr_ok) state_n = RESP;
            end
            RESP: begin
                if (flush && !owner) cancel_n = 1'b1;
                if (mem_data_ok) begin
                    state_n  = IDLE;
                    cancel_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cancel     <= 1'b0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_grant <= last_grant_n;
            cancel     <= cancel_n;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lat_wr    <= 1'b0;
            lat_size  <= 2'd0;
            lat_wstrb <= 4'd0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (grant_inst) begin
            lat_wr    <= inst_sram_wr;
            lat_size  <= inst_sram_size;
            lat_wstrb <= inst_sram_wstrb;
            lat_addr  <= inst_sram_addr;
            lat_wdata <= inst_sram_wdata;
        end else if (grant_data) begin
            lat_wr    <= data_sram_wr;
            lat_size  <= data_sram_size;
            lat_wstrb <= data_sram_wstrb;
            lat_addr  <= data_sram_addr;
            lat_wdata <= data_sram_wdata;
        end
    end

    assign resp_done = (state == RESP) && mem_data_ok;

    assign inst_sram_addr_ok = grant_inst;
    assign data_sram_addr_ok = grant_data;
    // Same-cycle flush also kills the fetch response
    assign inst_sram_data_ok = resp_done && !owner && !cancel && !flush;
    assign data_sram_data_ok = resp_done && owner;
    assign inst_sram_rdata   = mem_rdata;
    assign data_sram_rdata   = mem_rdata;

    assign mem_req   = (state == ADDR);
    assign mem_wr    = lat_wr;
    assign mem_size  = lat_size;
    assign mem_wstrb = lat_wstrb;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter with a transaction-level
// reference model compared every cycle plus literal spot checks.
module tb_sram_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        inst_req = 1'b0, inst_wr = 1'b0;
    logic [1:0]  inst_size = 2'd0;
    logic [3:0]  inst_wstrb = 4'd0;
    logic [31:0] inst_addr = '0, inst_wdata = '0;
    logic        inst_aok, inst_dok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = 2'd0;
    logic [3:0]  data_wstrb = 4'd0;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic        data_aok, data_dok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .inst_sram_req(inst_req), .inst_sram_wr(inst_wr),
        .inst_sram_size(inst_size), .inst_sram_wstrb(inst_wstrb),
        .inst_sram_addr(inst_addr), .inst_sram_wdata(inst_wdata),
        .inst_sram_addr_ok(inst_aok), .inst_sram_data_ok(inst_dok),
        .inst_sram_rdata(inst_rdata),
        .data_sram_req(data_req), .data_sram_wr(data_wr),
        .data_sram_size(data_size), .data_sram_wstrb(data_wstrb),
        .data_sram_addr(data_addr), .data_sram_wdata(data_wdata),
        .data_sram_addr_ok(data_aok), .data_sram_data_ok(data_dok),
        .data_sram_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one in-flight transaction record
    bit          m_live, m_iss, m_own_d, m_drop, m_prio_inst;
    bit          mf_wr;
    logic [1:0]  mf_size;
    logic [3:0]  mf_wstrb;
    logic [31:0] mf_addr, mf_wdata;

    task automatic model_step();
        bit wi, wd, dk;
        if (!resetn) begin
            chk("rst_inst_aok", inst_aok, 0);
            chk("rst_data_aok", data_aok, 0);
            chk("rst_inst_dok", inst_dok, 0);
            chk("rst_data_dok", data_dok, 0);
            chk("rst_mem_req", mem_req, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_mem_ctl", {mem_wr, mem_size, mem_wstrb}, 0);
            m_live = 0; m_iss = 0; m_own_d = 0; m_drop = 0;
            m_prio_inst = 1;
            mf_wr = 0; mf_size = 0; mf_wstrb = 0;
            mf_addr = 0; mf_wdata = 0;
            return;
        end
        wi = !m_live && inst_req && (!data_req || m_prio_inst);
        wd = !m_live && data_req && (!inst_req || !m_prio_inst);
        dk = m_live && m_iss && mem_data_ok;
        chk("inst_aok", inst_aok, wi);
        chk("data_aok", data_aok, wd);
        chk("inst_dok", inst_dok, dk && !m_own_d && !m_drop && !flush);
        chk("data_dok", data_dok, dk && m_own_d);
        chk("mem_req", mem_req, m_live && !m_iss);
        chk("mem_addr", mem_addr, mf_addr);
        chk("mem_wdata", mem_wdata, mf_wdata);
        chk("mem_ctl", {mem_wr, mem_size, mem_wstrb},
            {mf_wr, mf_size, mf_wstrb});
        chk("inst_rdata", inst_rdata, mem_rdata);
        chk("data_rdata", data_rdata, mem_rdata);
        if (mem_addr_ok) chk("proto_addr_ok", 1, m_live && !m_iss);
        if (mem_data_ok) chk("proto_data_ok", 1, m_live && m_iss);
        if (wi || wd) begin
            m_live = 1; m_iss = 0; m_drop = 0;
            m_own_d = wd; m_prio_inst = wd;
            mf_wr    = wd ? data_wr    : inst_wr;
            mf_size  = wd ? data_size  : inst_size;
            mf_wstrb = wd ? data_wstrb : inst_wstrb;
            mf_addr  = wd ? data_addr  : inst_addr;
            mf_wdata = wd ? data_wdata : inst_wdata;
        end else if (m_live) begin
            if (flush && !m_own_d) m_drop = 1;
            if (!m_iss) begin
                if (mem_addr_ok) m_iss = 1;
            end else if (mem_data_ok) begin
                m_live = 0;
                m_drop = 0;
            end
        end
    endtask

    always @(negedge clk) model_step();

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #3;
    endtask

    task automatic clr();
        inst_req = 0; data_req = 0; flush = 0;
        mem_addr_ok = 0; mem_data_ok = 0;
    endtask

    task automatic do_reset();
        resetn = 0;
        clr();
        tick();
        tick();
        resetn = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        #2;
        chk("init_mem_req", mem_req, 0);
        do_reset();

        // Single fetch read
        inst_req = 1; inst_wr = 0; inst_size = 2;
        inst_addr = 32'h1C000000;
        look();
        chk("t1_inst_aok", inst_aok, 1);
        tick();
        inst_req = 0; mem_addr_ok = 1;
        look();
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 32'h1C000000);
        tick();
        mem_addr_ok = 0;
        look();
        chk("t1_mem_req_off", mem_req, 0);
        tick();
        mem_data_ok = 1; mem_rdata = 32'h02800C0C;
        look();
        chk("t1_inst_dok", inst_dok, 1);
        chk("t1_inst_rdata", inst_rdata, 32'h02800C0C);
        chk("t1_data_dok", data_dok, 0);
        tick();
        clr();

        // Simultaneous requests after reset: inst, data, inst
        do_reset();
        inst_req = 1; inst_addr = 32'h1C000010;
        data_req = 1; data_wr = 0; data_size = 2;
        data_addr = 32'h00001000;
        for (int r = 0; r < 3; r++) begin
            look();
            chk("t2_inst_aok", inst_aok, (r % 2) == 0);
            chk("t2_data_aok", data_aok, (r % 2) == 1);
            tick();
            mem_addr_ok = 1;
            look();
            chk("t2_mem_addr", mem_addr,
                (r % 2) ? 32'h00001000 : 32'h1C000010);
            tick();
            mem_addr_ok = 0; mem_data_ok = 1;
            mem_rdata = 32'hA0000000 + r;
            look();
            chk("t2_inst_dok", inst_dok, (r % 2) == 0);
            chk("t2_data_dok", data_dok, (r % 2) == 1);
            tick();
            mem_data_ok = 0;
        end
        clr();
        tick();

        // Store with stalled bus
        data_req = 1; data_wr = 1; data_size = 2;
        data_addr = 32'h1FAF0000; data_wstrb = 4'b0011;
        data_wdata = 32'h1234ABCD;
        look();
        chk("t3_data_aok", data_aok, 1);
        tick();
        data_req = 0; data_addr = 32'hDEADBEEF;
        data_wdata = 32'h55555555; data_wstrb = 4'hF;
        for (int i = 0; i < 6; i++) begin
            mem_addr_ok = (i == 5);
            look();
            chk("t3_mem_req", mem_req, 1);
            chk("t3_mem_addr", mem_addr, 32'h1FAF0000);
            chk("t3_mem_wdata", mem_wdata, 32'h1234ABCD);
            chk("t3_mem_wstrb", mem_wstrb, 4'b0011);
            chk("t3_mem_wr", mem_wr, 1);
            tick();
        end
        mem_addr_ok = 0;
        look();
        chk("t3_mem_req_off", mem_req, 0);
        tick();
        mem_data_ok = 1;
        look();
        chk("t3_data_dok", data_dok, 1);
        tick();
        clr();

        // Flush during fetch RESP
        inst_req = 1; inst_addr = 32'h1C000020;
        look();
        chk("t4_inst_aok", inst_aok, 1);
        tick();
        inst_req = 0; mem_addr_ok = 1;
        tick();
        mem_addr_ok = 0; flush = 1;
        tick();
        flush = 0; mem_data_ok = 1; mem_rdata = 32'h11111111;
        look();
        chk("t4_inst_dok_drop", inst_dok, 0);
        tick();
        mem_data_ok = 0; inst_req = 1; inst_addr = 32'h1C000024;
        look();
        chk("t4_inst_aok2", inst_aok, 1);
        tick();
        inst_req = 0; mem_addr_ok = 1;
        tick();
        mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h22222222;
        look();
        chk("t4_inst_dok2", inst_dok, 1);
        chk("t4_inst_rdata2", inst_rdata, 32'h22222222);
        tick();
        clr();

        // Flush in the same cycle as the fetch response
        inst_req = 1; inst_addr = 32'h1C000028;
        tick();
        inst_req = 0; mem_addr_ok = 1;
        tick();
        mem_addr_ok = 0; mem_data_ok = 1; flush = 1;
        look();
        chk("t4b_inst_dok", inst_dok, 0);
        tick();
        clr();

        // Flush during store ADDR
        data_req = 1; data_wr = 1; data_addr = 32'h00002000;
        data_wdata = 32'hCAFEF00D; data_wstrb = 4'hF;
        tick();
        data_req = 0; flush = 1;
        look();
        chk("t5_mem_req", mem_req, 1);
        tick();
        flush = 0; mem_addr_ok = 1;
        tick();
        mem_addr_ok = 0; mem_data_ok = 1;
        look();
        chk("t5_data_dok", data_dok, 1);
        tick();
        clr();

        // Async reset mid-ADDR
        inst_req = 1; inst_addr = 32'h1C000030;
        tick();
        inst_req = 0;
        look();
        chk("t6_mem_req_pre", mem_req, 1);
        tick();
        resetn = 0;
        #1;
        chk("t6_mem_req_rst", mem_req, 0);
        chk("t6_mem_addr_rst", mem_addr, 0);
        tick();
        resetn = 1;
        data_req = 1; data_wr = 0; data_addr = 32'h00003000;
        look();
        chk("t6_data_aok", data_aok, 1);
        tick();
        data_req = 0; mem_addr_ok = 1;
        tick();
        mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h33333333;
        look();
        chk("t6_data_dok", data_dok, 1);
        tick();
        clr();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
